// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: two-digit BCD up/down counter stepped by rising edges of an
// asynchronous slow tick, with registered 7-segment drivers for HEX1/HEX0.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank the tens display while it is 0).
`timescale 1ns/1ps

// One registered 7-segment digit driver. Decodes in active-high form and applies
// the board polarity once at the register input.
module bcd_seg_digit #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_ZERO     = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // XOR mask turning active-high patterns into the board polarity
    localparam logic [6:0] POL     = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    // What a zero digit looks like right after reset (blank if zero is suppressed)
    localparam logic [6:0] RST_LIT = BLANK_ZERO ? 7'h00 : 7'h3F;

    // {g,f,e,d,c,b,a}, 1 = lit; anything outside 0..9 is dark
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    logic [6:0] lit;

    generate
        if (BLANK_ZERO) begin : g_blank
            assign lit = (digit == 4'd0) ? 7'h00 : decode(digit);
        end else begin : g_plain
            assign lit = decode(digit);
        end
    endgenerate

    // Display register: follows the count one cycle later
    always_ff @(posedge clk_in) begin
        if (!rst_n) seg <= RST_LIT ^ POL;
        else        seg <= lit ^ POL;
    end
endmodule

module bcd_tick_counter #(
    parameter int MAX_COUNT      = 59,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       en,
    input  logic       up_dn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count_bcd,
    output logic       carry,
    output logic [6:0] hex0,
    output logic [6:0] hex1
);
    localparam int         NUM_DIGITS = 2;
    localparam int         ARM_STAGES = 3;
    localparam logic [3:0] MAX_TENS   = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_UNITS  = 4'(MAX_COUNT % 10);
    localparam logic [7:0] MAX_BCD    = {MAX_TENS, MAX_UNITS};

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic                  s1, s2, s3;
    logic [ARM_STAGES-1:0] arm_pipe;
    logic                  rise;
    logic [3:0]            units, tens;
    logic [7:0]            step_val;
    logic                  step_wrap;
    logic                  ld_ok;

    // Two-flop synchroniser plus history flop; arm_pipe fills with ones after
    // reset so an input already high at release cannot look like an edge
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            arm_pipe <= '0;
        end else begin
            s1       <= tick_in;
            s2       <= s1;
            s3       <= s2;
            arm_pipe <= {arm_pipe[ARM_STAGES-2:0], 1'b1};
        end
    end

    assign rise  = s2 & ~s3 & arm_pipe[ARM_STAGES-1];
    assign units = count_bcd[3:0];
    assign tens  = count_bcd[7:4];

    // Next count for one step in the requested direction, nibble-wise BCD
    always_comb begin
        step_val  = count_bcd;
        step_wrap = 1'b0;
        if (up_dn) begin
            if (count_bcd == MAX_BCD) begin
                step_val  = 8'h00;
                step_wrap = 1'b1;
            end else if (units == 4'd9) begin
                step_val = {tens + 4'd1, 4'd0};
            end else begin
                step_val = {tens, units + 4'd1};
            end
        end else begin
            if (count_bcd == 8'h00) begin
                step_val  = MAX_BCD;
                step_wrap = 1'b1;
            end else if (units == 4'd0) begin
                step_val = {tens - 4'd1, 4'd9};
            end else begin
                step_val = {tens, units - 4'd1};
            end
        end
    end

    // With both nibbles valid, BCD order equals numeric order, so a plain
    // byte compare against MAX_BCD is the range check
    assign ld_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                   (load_val <= MAX_BCD);

    // Count register: load beats step; carry only on the wrapping step
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count_bcd <= 8'h00;
            carry     <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (load) begin
                count_bcd <= ld_ok ? load_val : 8'h00;
            end else if (rise && en) begin
                count_bcd <= step_val;
                carry     <= step_wrap;
            end
        end
    end

    logic [NUM_DIGITS-1:0][6:0] seg;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            bcd_seg_digit #(
                .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
                .BLANK_ZERO     ((g == 1) && LZB)
            ) u_dig (
                .clk_in (clk_in),
                .rst_n  (rst_n),
                .digit  (count_bcd[g*4 +: 4]),
                .seg    (seg[g])
            );
        end
    endgenerate

    assign hex0 = seg[0];
    assign hex1 = seg[1];
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter (MAX_COUNT=59, active-low segments).
`timescale 1ns/1ps

module tb_bcd_tick_counter;
    logic       clk_in = 1'b0;
    logic       rst_n, tick_in, en, up_dn, load;
    logic [7:0] load_val;
    logic [7:0] count_bcd;
    logic       carry;
    logic [6:0] hex0, hex1;

    int n_cmp = 0;
    int n_err = 0;

    // Active-low patterns for digits 0..9
    logic [6:0] seg_exp [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_tick_counter #(.MAX_COUNT(59), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .count_bcd (count_bcd),
        .carry     (carry),
        .hex0      (hex0),
        .hex1      (hex1)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] hex1_exp(input int t);
`ifdef LEADING_ZERO_BLANK_EN
        if (t == 0) return 7'h7F;
`endif
        return seg_exp[t];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One tick: count holds two edges, changes on the third, displays follow one later
    task automatic tick(input int from, input int to, input logic wrap, input string tag);
        tick_in = 1'b1;
        step(); step();
        chk({tag, "_hold"}, count_bcd, bcd(from));
        step();
        chk({tag, "_cnt"}, count_bcd, bcd(to));
        chk({tag, "_cy"}, {7'd0, carry}, {7'd0, wrap});
        tick_in = 1'b0;
        step();
        chk({tag, "_cy0"}, {7'd0, carry}, 8'd0);
        chk({tag, "_hex0"}, {1'b0, hex0}, {1'b0, seg_exp[to % 10]});
        chk({tag, "_hex1"}, {1'b0, hex1}, {1'b0, hex1_exp(to / 10)});
        step(); step();
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b1; en = 1'b1; up_dn = 1'b1;
        load = 1'b0; load_val = 8'h00;

        // Reset held two cycles with tick already high
        step(); step();
        chk("rst_cnt", count_bcd, 8'h00);
        chk("rst_cy", {7'd0, carry}, 8'd0);
        chk("rst_hex0", {1'b0, hex0}, 8'h40);
        chk("rst_hex1", {1'b0, hex1}, {1'b0, hex1_exp(0)});
        rst_n = 1'b1;
        repeat (8) step();
        chk("rel_high_cnt", count_bcd, 8'h00);
        tick_in = 1'b0;
        repeat (3) step();
        chk("rel_low_cnt", count_bcd, 8'h00);

        // Full up sweep 00..59 and wrap
        for (int i = 1; i <= 60; i++)
            tick(i - 1, i % 60, (i == 60), $sformatf("up%0d", i));

        // Down: wrap to max, plain decrement, tens borrow
        up_dn = 1'b0;
        tick(0, 59, 1'b1, "dn_wrap");
        tick(59, 58, 1'b0, "dn");
        do_load(8'h10);
        chk("ld10", count_bcd, 8'h10);
        tick(10, 9, 1'b0, "dn_borrow");

        // Load coincident with the accepting edge wins; the tick is dropped
        tick_in = 1'b1;
        step(); step();
        load = 1'b1; load_val = 8'h42;
        step();
        load = 1'b0;
        chk("ld_rise_cnt", count_bcd, 8'h42);
        chk("ld_rise_cy", {7'd0, carry}, 8'd0);
        tick_in = 1'b0;
        repeat (4) step();
        chk("ld_rise_after", count_bcd, 8'h42);

        // Illegal / out-of-range loads clear; max is legal
        do_load(8'h4A); chk("ld_4A", count_bcd, 8'h00);
        do_load(8'h75); chk("ld_75", count_bcd, 8'h00);
        do_load(8'h59); chk("ld_59", count_bcd, 8'h59);
        do_load(8'h60); chk("ld_60", count_bcd, 8'h00);

        // Disabled ticks are discarded, not queued
        do_load(8'h33);
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick(33, 33, 1'b0, $sformatf("en0_%0d", i));
        en = 1'b1;
        repeat (8) step();
        chk("en1_no_burst", count_bcd, 8'h33);

        // Leading-zero handling on the tens display
        do_load(8'h05); step();
        chk("lz05_hex0", {1'b0, hex0}, 8'h12);
        chk("lz05_hex1", {1'b0, hex1}, {1'b0, hex1_exp(0)});
        do_load(8'h15); step();
        chk("lz15_hex1", {1'b0, hex1}, 8'h79);

        // Reset mid-tick drops the count and the tick in flight
        do_load(8'h27);
        tick_in = 1'b1;
        step();
        rst_n = 1'b0; tick_in = 1'b0;
        step();
        chk("midrst_cnt", count_bcd, 8'h00);
        rst_n = 1'b1;
        repeat (6) step();
        chk("midrst_after", count_bcd, 8'h00);
        up_dn = 1'b1;
        tick(0, 1, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
